// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor: STAGES register slices, each
// resolving SW result bits with a two-level CLA. Optional CLA_ADDSUB_SAT_EN adds per-beat saturation.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef CLA_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;
  localparam int L  = STAGES - 1;

  // Returns {carry_out, sum}: group g/p first, then lookahead across groups.
  function automatic logic [SW:0] cla(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                      input logic ci);
    logic [SW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '1;
    c  = '0;
    for (int j = 0; j < NG; j++)
      for (int i = 0; i < GROUP; i++) begin
        gg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & gg[j]);
        gp[j] = gp[j] & p[j*GROUP+i];
      end
    gc[0] = ci;
    for (int j = 0; j < NG; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < NG; j++) begin
      c[j*GROUP] = gc[j];
      for (int i = 1; i < GROUP; i++)
        c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
    end
    return {gc[NG], p ^ c};
  endfunction

  logic [STAGES-1:0] v, adv, load;

  always_comb begin
    logic nxt, t;
    adv = '0;
    nxt = out_ready;
    for (int k = L; k >= 0; k--) begin
      t      = v[k] & nxt;
      adv[k] = t;
      nxt    = ~v[k] | t;
    end
  end

  assign load      = ~v | adv;
  assign in_ready  = load[0];
  assign out_valid = v[L];

  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else begin
      if (load[0]) v[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        if (load[k]) v[k] <= v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operands shrink by one slice per stage; the result word grows by one.
    localparam int RW = WIDTH - k*SW;
    logic [RW-1:0]       xa, xb;
    logic                xc, xv;
    logic [SW:0]         r;
    logic [(k+1)*SW-1:0] ws;
`ifdef CLA_ADDSUB_SAT_EN
    logic                xsat;
`endif

    if (k == 0) begin : g_src
      assign xa = a;
      assign xb = b ^ {WIDTH{sub}};
      assign xc = sub;
      assign xv = in_valid;
      assign ws = r[SW-1:0];
`ifdef CLA_ADDSUB_SAT_EN
      assign xsat = sat;
`endif
    end else begin : g_src
      assign xa = g_st[k-1].g_mid.ra;
      assign xb = g_st[k-1].g_mid.rb;
      assign xc = g_st[k-1].g_mid.rc;
      assign xv = v[k-1];
      assign ws = {r[SW-1:0], g_st[k-1].g_mid.rs};
`ifdef CLA_ADDSUB_SAT_EN
      assign xsat = g_st[k-1].g_mid.rsat;
`endif
    end

    assign r = cla(xa[SW-1:0], xb[SW-1:0], xc);

    if (k < L) begin : g_mid
      logic [RW-SW-1:0]    ra, rb;
      logic [(k+1)*SW-1:0] rs;
      logic                rc;
`ifdef CLA_ADDSUB_SAT_EN
      logic                rsat;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          ra <= '0;
          rb <= '0;
          rs <= '0;
          rc <= 1'b0;
`ifdef CLA_ADDSUB_SAT_EN
          rsat <= 1'b0;
`endif
        end else if (load[k] && xv) begin
          ra <= xa[RW-1:SW];
          rb <= xb[RW-1:SW];
          rs <= ws;
          rc <= r[SW];
`ifdef CLA_ADDSUB_SAT_EN
          rsat <= xsat;
`endif
        end
      end
    end else begin : g_last
      logic             cmsb, ovf_n;
      logic [WIDTH-1:0] s_n;
      always_comb begin
        // carry into the MSB recovered from its own sum bit
        cmsb  = xa[SW-1] ^ xb[SW-1] ^ r[SW-1];
        ovf_n = cmsb ^ r[SW];
        s_n   = ws;
`ifdef CLA_ADDSUB_SAT_EN
        if (xsat && ovf_n)
          s_n = ws[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          s     <= '0;
          c_out <= 1'b0;
          ovf   <= 1'b0;
          zero  <= 1'b0;
        end else if (load[k] && xv) begin
          s     <= s_n;
          c_out <= r[SW];
          ovf   <= ovf_n;
          zero  <= ~|s_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed table-driven bench for cla_addsub_pipe (default WIDTH=32, STAGES=2).
module tb_cla_addsub_pipe;
  localparam int LAT = 2;

  logic        clk, rst, in_valid, in_ready, sub, sat;
  logic [31:0] a, b, s;
  logic        out_valid, out_ready, c_out, ovf, zero;

  int total = 0;
  int bad   = 0;

  cla_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
`ifdef CLA_ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a, b;
    logic        sub, sat;
    logic [31:0] s;
    logic        c, o, z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int id);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = t.a; b = t.b; sub = t.sub; sat = t.sat;
    #1 chk($sformatf("v%0d in_ready", id), in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("v%0d latency", id), n, LAT);
    chk($sformatf("v%0d s", id), s, t.s);
    chk($sformatf("v%0d c_out", id), c_out, t.c);
    chk($sformatf("v%0d ovf", id), ovf, t.o);
    chk($sformatf("v%0d zero", id), zero, t.z);
    @(posedge clk);
    #1 chk($sformatf("v%0d drained", id), out_valid, 0);
    chk($sformatf("v%0d s hold", id), s, t.s);
  endtask

  initial begin
    int sent, rcv, occ, cyc;
    logic exp_rdy, acc, dlv;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst s", s, 0);
    chk("rst c_out", c_out, 0);
    chk("rst ovf", ovf, 0);
    chk("rst zero", zero, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

`ifdef CLA_ADDSUB_SAT_EN
    begin
      vec_t t;
      t = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
      run_vec(t, 100);
      t = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
      run_vec(t, 101);
    end
`endif

    // back-pressure stream: out_ready follows 1,0,0,1,0,0,...
    sent = 0; rcv = 0; occ = 0; cyc = 0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      a = sent; b = sent; sub = 1'b0; sat = 1'b0;
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      chk($sformatf("bp c%0d in_ready", cyc), in_ready, exp_rdy);
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        chk($sformatf("bp beat%0d s", rcv), s, 2 * rcv);
        rcv++;
      end
      if (acc) sent++;
      occ = occ + int'(acc) - int'(dlv);
      cyc++;
    end
    chk("bp all delivered", rcv, 8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("bp no duplicate", out_valid, 0);
    end

    // reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h1; b = 32'h1; sub = 1'b0;
    @(negedge clk);
    a = 32'h2; b = 32'h2;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("mid out_valid before rst", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst s", s, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("mid flushed", out_valid, 0);
    end
    run_vec(tbl[0], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
